// File: rtl/rca_mw_seq_if.sv
// -----------------------------------------------------------------------------
// rca_mw_seq_if
// Purpose : operand/result handshake bundle for the multi-word add sequencer.
// Signals : in_valid/in_ready   - operand pair handshake (producer -> sequencer)
//           in_a/in_b           - wide operands, word k at [k*WIDTH +: WIDTH]
//           in_cin              - carry-in to word 0
//           in_sub              - subtract select (only with RCA_SUB_EN)
//           out_valid/out_ready - result handshake (sequencer -> consumer)
//           out_sum/out_cout    - wide sum and carry-out of the top word
// Modports: master = operand producer / result consumer, slave = sequencer.
// Macro   : RCA_SUB_EN adds the in_sub signal.
// -----------------------------------------------------------------------------
interface rca_mw_seq_if #(
  parameter int WIDTH  = 64,
  parameter int NWORDS = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH*NWORDS-1:0]  in_a;
  logic [WIDTH*NWORDS-1:0]  in_b;
  logic                     in_cin;
`ifdef RCA_SUB_EN
  logic                     in_sub;
`endif
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH*NWORDS-1:0]  out_sum;
  logic                     out_cout;

`ifdef RCA_SUB_EN
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`endif
endinterface

// File: rtl/rca_mw_seq.sv
// -----------------------------------------------------------------------------
// rca_mw_seq
// Purpose : builds a WIDTH*NWORDS-bit add out of one shared WIDTH-bit
//           ripple-carry adder, one word per cycle, LS word first, carry
//           chained through a register. The result is held until accepted.
// Ports   : clk, rst_n        - clock, synchronous active-low reset
//           bus (slave)       - operand/result handshake (rca_mw_seq_if)
//           add_a/add_b/add_cin - drive to the external adder (0 outside RUN)
//           add_sum/add_cout  - combinational result from the external adder
// Macro   : RCA_SUB_EN enables in_sub (A - B - cin via inverted B and carry).
// -----------------------------------------------------------------------------
module rca_mw_seq #(
  parameter int WIDTH  = 64,
  parameter int NWORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rca_mw_seq_if.slave       bus,
  output logic [WIDTH-1:0]  add_a,
  output logic [WIDTH-1:0]  add_b,
  output logic              add_cin,
  input  logic [WIDTH-1:0]  add_sum,
  input  logic              add_cout
);

  localparam int TW    = WIDTH * NWORDS;
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [TW-1:0]      r_a;
  logic [TW-1:0]      r_b;
  logic [TW-1:0]      r_sum;
  logic               r_cout;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   w_a_word;
  logic [WIDTH-1:0]   w_b_word;
  logic               w_cin0;
`ifdef RCA_SUB_EN
  logic               r_sub;
`endif

  // Initial carry: subtraction is A + ~B + ~cin, so the carry-in is inverted.
`ifdef RCA_SUB_EN
  assign w_cin0 = bus.in_cin ^ bus.in_sub;
`else
  assign w_cin0 = bus.in_cin;
`endif

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) w_next_state = S_RUN;
        else              w_next_state = S_IDLE;
      end
      S_RUN: begin
        if (r_idx == LAST_IDX) w_next_state = S_DONE;
        else                   w_next_state = S_RUN;
      end
      S_DONE: begin
        if (bus.out_ready) w_next_state = S_IDLE;
        else               w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Adder drive: current word pair during RUN, all zero otherwise.
  always_comb begin
    w_a_word = r_a[r_idx*WIDTH +: WIDTH];
`ifdef RCA_SUB_EN
    w_b_word = r_sub ? ~r_b[r_idx*WIDTH +: WIDTH] : r_b[r_idx*WIDTH +: WIDTH];
`else
    w_b_word = r_b[r_idx*WIDTH +: WIDTH];
`endif
    if (r_state == S_RUN) begin
      add_a   = w_a_word;
      add_b   = w_b_word;
      add_cin = r_carry;
    end else begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
    end
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef RCA_SUB_EN
      r_sub       <= 1'b0;
`endif
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state == S_IDLE);
      r_out_valid <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_carry <= w_cin0;
            r_idx   <= '0;
`ifdef RCA_SUB_EN
            r_sub   <= bus.in_sub;
`endif
          end else begin
            r_idx   <= r_idx;
          end
        end
        S_RUN: begin
          r_sum[r_idx*WIDTH +: WIDTH] <= add_sum;
          r_carry <= add_cout;
          if (r_idx == LAST_IDX) begin
            r_cout <= add_cout;
            r_idx  <= '0;
          end else begin
            r_idx  <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          r_idx <= r_idx;
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_cout;

endmodule

// File: tb/tb_rca_mw_seq.sv
module tb_rca_mw_seq;
  localparam int WIDTH  = 64;
  localparam int NWORDS = 4;
  localparam int TW     = WIDTH * NWORDS;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  int               n_cmp;
  int               n_err;

  rca_mw_seq_if #(.WIDTH(WIDTH), .NWORDS(NWORDS)) bus();

  rca_mw_seq #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // Behavioural stand-in for the external 64-bit ripple-carry adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_sum !== '0) begin n_err++; $display("FAIL reset_out_sum: got %h want 0", bus.out_sum); end
    n_cmp++; if (bus.out_cout !== 1'b0) begin n_err++; $display("FAIL reset_out_cout: got %0b want 0", bus.out_cout); end
    n_cmp++; if ({add_a, add_b, add_cin} !== '0) begin n_err++; $display("FAIL reset_adder_quiet: got a=%h b=%h c=%0b want 0", add_a, add_b, add_cin); end
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    drive_op(TW'(10), TW'(35), 1'b0);
    tick();                                   // accept edge T
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_run: got %0b want 0", bus.in_ready); end
    n_cmp++; if (add_a !== 64'd10 || add_b !== 64'd35 || add_cin !== 1'b0) begin n_err++; $display("FAIL basic_word0_drive: got a=%0d b=%0d c=%0b want 10 35 0", add_a, add_b, add_cin); end
    repeat (3) tick();                        // edges T+1..T+3
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %0b want 0", bus.out_valid); end
    tick();                                   // edge T+4
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid: got %0b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_sum !== TW'(45)) begin n_err++; $display("FAIL basic_sum: got %0d want 45", bus.out_sum); end
    n_cmp++; if (bus.out_cout !== 1'b0) begin n_err++; $display("FAIL basic_cout: got %0b want 0", bus.out_cout); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_done: got %0b want 0", bus.in_ready); end
    n_cmp++; if (add_a !== '0) begin n_err++; $display("FAIL basic_adder_quiet_done: got %h want 0", add_a); end
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_back_idle: got rdy=%0b vld=%0b want 1 0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_carry();
    logic [TW-1:0] exp_sum;
    exp_sum = 256'h1_0000_0000_0000_0000;
    bus.out_ready = 1'b1;
    drive_op(256'hFFFF_FFFF_FFFF_FFFF, TW'(1), 1'b0);
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (add_cin !== 1'b0) begin n_err++; $display("FAIL carry_cin_run0: got %0b want 0", add_cin); end
    tick();
    n_cmp++; if (add_cin !== 1'b1 || add_a !== 64'd0 || add_b !== 64'd0) begin n_err++; $display("FAIL carry_cin_run1: got c=%0b a=%h b=%h want 1 0 0", add_cin, add_a, add_b); end
    repeat (3) tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_sum) begin n_err++; $display("FAIL carry_sum: got vld=%0b sum=%h want 1 %h", bus.out_valid, bus.out_sum, exp_sum); end
    n_cmp++; if (bus.out_cout !== 1'b0) begin n_err++; $display("FAIL carry_cout: got %0b want 0", bus.out_cout); end
    tick();
  endtask

  task automatic test_overflow();
    logic [TW-1:0] ones;
    ones = {TW{1'b1}};
    bus.out_ready = 1'b1;
    drive_op(ones, '0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_sum !== '0) begin n_err++; $display("FAIL ovf_sum: got vld=%0b sum=%h want 1 0", bus.out_valid, bus.out_sum); end
    n_cmp++; if (bus.out_cout !== 1'b1) begin n_err++; $display("FAIL ovf_cout: got %0b want 1", bus.out_cout); end
    tick();
    drive_op(TW'(866945), TW'(3324752), 1'b1);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    n_cmp++; if (bus.out_sum !== TW'(4191698)) begin n_err++; $display("FAIL ovf_small_sum: got %0d want 4191698", bus.out_sum); end
    n_cmp++; if (bus.out_cout !== 1'b0) begin n_err++; $display("FAIL ovf_small_cout: got %0b want 0", bus.out_cout); end
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive_op(TW'(7), TW'(8), 1'b1);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_sum !== TW'(16) || bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_%0d: got vld=%0b sum=%0d rdy=%0b want 1 16 0", i, bus.out_valid, bus.out_sum, bus.in_ready); end
      if (i % 2 == 0) drive_op(TW'(1000), TW'(1000), 1'b0);
      else            bus.in_valid = 1'b0;
      tick();
    end
    n_cmp++; if (bus.out_sum !== TW'(16) || bus.out_cout !== 1'b0) begin n_err++; $display("FAIL bp_after_pulses: got sum=%0d cout=%0b want 16 0", bus.out_sum, bus.out_cout); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got rdy=%0b vld=%0b want 1 0", bus.in_ready, bus.out_valid); end
    drive_op(TW'(5), TW'(6), 1'b0);
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_next_accept: got rdy=%0b want 0", bus.in_ready); end
    repeat (4) tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_sum !== TW'(11)) begin n_err++; $display("FAIL bp_next_sum: got vld=%0b sum=%0d want 1 11", bus.out_valid, bus.out_sum); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bus.out_ready = 1'b1;
    drive_op(TW'(500), TW'(600), 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();                                   // first RUN edge; now in second RUN cycle
    n_cmp++; if (bus.out_sum !== TW'(1100)) begin n_err++; $display("FAIL rst_partial: got %0d want 1100", bus.out_sum); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_sum !== '0) begin n_err++; $display("FAIL rst_abort: got vld=%0b sum=%0d want 0 0", bus.out_valid, bus.out_sum); end
    n_cmp++; if ({add_a, add_b, add_cin} !== '0) begin n_err++; $display("FAIL rst_adder_quiet: got a=%h b=%h c=%0b want 0", add_a, add_b, add_cin); end
    rst_n = 1'b1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b want 1", bus.in_ready); end
    drive_op(TW'(23), TW'(132), 1'b1);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_sum !== TW'(156)) begin n_err++; $display("FAIL rst_fresh_sum: got vld=%0b sum=%0d want 1 156", bus.out_valid, bus.out_sum); end
    tick();
  endtask

`ifdef RCA_SUB_EN
  task automatic test_sub();
    logic [TW-1:0] exp_neg;
    exp_neg = ~TW'(64);                       // 2^256 - 65
    bus.out_ready = 1'b1;
    bus.in_sub    = 1'b1;
    drive_op(TW'(100), TW'(35), 1'b0);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    n_cmp++; if (bus.out_sum !== TW'(65) || bus.out_cout !== 1'b1) begin n_err++; $display("FAIL sub_pos: got sum=%0d cout=%0b want 65 1", bus.out_sum, bus.out_cout); end
    tick();
    drive_op(TW'(35), TW'(100), 1'b0);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    n_cmp++; if (bus.out_sum !== exp_neg || bus.out_cout !== 1'b0) begin n_err++; $display("FAIL sub_neg: got sum=%h cout=%0b want %h 0", bus.out_sum, bus.out_cout, exp_neg); end
    tick();
    bus.in_sub = 1'b0;
  endtask
`endif

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
`ifdef RCA_SUB_EN
    bus.in_sub    = 1'b0;
`endif
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
`ifdef RCA_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
